shared_ram_slot_arbiter: RTL and testbench

//  Shares one single-port synchronous work RAM among three requesters: the video fetch port and CPU0/CPU1.

---
 rtl/shared_ram_slot_arbiter_pkg.sv | 25 ++
 rtl/shared_ram_slot_arbiter_rr_arb2.sv | 53 +++++
 rtl/shared_ram_slot_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_shared_ram_slot_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ram_slot_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_ram_slot_arbiter_pkg
//   Shared definitions for the work-RAM slot arbiter: default RAM geometry,
//   the pipeline tag that follows each RAM access from decision to output,
//   and a helper that maps a CPU index onto its tag.
// ---------------------------------------------------------------------------
package shared_ram_slot_arbiter_pkg;

  localparam int AW_DEF = 11;  // RAM address width
  localparam int DW_DEF = 8;   // RAM data width

  // Identifies the owner of an access as it travels down the pipeline.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU0 = 2'd2,
    TAG_CPU1 = 2'd3
  } tag_e;

  // CPU index (0/1) to pipeline tag.
  function automatic tag_e cpu_tag(input logic idx);
    return idx ? TAG_CPU1 : TAG_CPU0;
  endfunction

endpackage

// File: rtl/shared_ram_slot_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// shared_ram_slot_arbiter_rr_arb2
//   Two-way round-robin picker (rr_arb2) for the two CPU requesters.
//   The preferred requester is the one the pointer names; if it is not
//   requesting, the other one is picked. When a grant is actually used
//   (i_advance high), the pointer moves to the requester that lost.
// Ports
//   i_clk      core clock
//   i_rst_n    asynchronous active-low reset (pointer returns to CPU0)
//   i_req      [1:0] eligible requesters (bit n = CPUn)
//   i_advance  grant is consumed this cycle; update the pointer
//   o_gnt      [1:0] one-hot grant (combinational)
// ---------------------------------------------------------------------------
module shared_ram_slot_arbiter_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    if (ptr_q == 1'b0) begin
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
    end else begin
      if (i_req[1])      o_gnt = 2'b10;
      else if (i_req[0]) o_gnt = 2'b01;
    end
  end

  // After granting CPU0 the pointer names CPU1 and vice versa; idle or
  // video-owned cycles leave it untouched.
  always_comb begin
    ptr_d = ptr_q;
    if (i_advance && (o_gnt != 2'b00)) begin
      ptr_d = o_gnt[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_ram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// shared_ram_slot_arbiter
//   Shares one single-port synchronous work RAM between the video fetch port
//   and two CPUs. Video owns the RAM in its strobe cycle; the CPUs share the
//   remaining cycles round-robin. One access per clock, four stages:
//     D (C)   : pick winner, form command
//     M (C+1) : command on o_ram_*
//     R (C+2) : RAM read data arrives, captured per tag
//     O (C+3) : ack / valid pulse, read data presented
// Ports
//   i_clk, i_rst_n                    core clock, async active-low reset
//   i_vid_cen, i_vid_addr             video slot strobe and read address
//   o_vid_rdata, o_vid_valid          video read data and its 1-cycle strobe
//   i_cpuN_req/we/addr/wdata          CPU level request (held until ack)
//   o_cpuN_ack, o_cpuN_rdata          completion pulse; read data held
//   o_ram_en/we/addr/wdata            registered RAM command
//   i_ram_rdata                       RAM data, valid the cycle after en
// ---------------------------------------------------------------------------
module shared_ram_slot_arbiter
  import shared_ram_slot_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vid_cen,
  input  logic [AW-1:0] i_vid_addr,
  output logic [DW-1:0] o_vid_rdata,
  output logic          o_vid_valid,
  input  logic          i_cpu0_req,
  input  logic          i_cpu0_we,
  input  logic [AW-1:0] i_cpu0_addr,
  input  logic [DW-1:0] i_cpu0_wdata,
  output logic          o_cpu0_ack,
  output logic [DW-1:0] o_cpu0_rdata,
  input  logic          i_cpu1_req,
  input  logic          i_cpu1_we,
  input  logic [AW-1:0] i_cpu1_addr,
  input  logic [DW-1:0] i_cpu1_wdata,
  output logic          o_cpu1_ack,
  output logic [DW-1:0] o_cpu1_rdata,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  // ---------------------------------------------------------------------
  // CPU inputs gathered into indexable form
  // ---------------------------------------------------------------------
  logic [1:0]    cpu_req;
  logic [1:0]    cpu_we;
  logic [AW-1:0] cpu_addr  [2];
  logic [DW-1:0] cpu_wdata [2];

  assign cpu_req      = {i_cpu1_req, i_cpu0_req};
  assign cpu_we       = {i_cpu1_we, i_cpu0_we};
  assign cpu_addr[0]  = i_cpu0_addr;
  assign cpu_addr[1]  = i_cpu1_addr;
  assign cpu_wdata[0] = i_cpu0_wdata;
  assign cpu_wdata[1] = i_cpu1_wdata;

  logic [1:0]    busy;        // CPUn has an access in flight
  logic [1:0]    cpu_ack;
  logic [DW-1:0] cpu_rdata [2];

  // ---------------------------------------------------------------------
  // Stage D: winner selection
  // ---------------------------------------------------------------------
  logic [1:0] eligible;
  logic [1:0] rr_gnt;

  // A CPU stays ineligible through its ack cycle, so a request still held
  // high when the ack appears is not mistaken for a fresh access.
  assign eligible = cpu_req & ~busy;

  // The pointer only moves when a CPU really takes the slot, i.e. when
  // video does not own this cycle.
  shared_ram_slot_arbiter_rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (eligible),
    .i_advance (~i_vid_cen),
    .o_gnt     (rr_gnt)
  );

  // Stage M registers and their next-state values
  logic          ram_en_q,    ram_en_d;
  logic          ram_we_q,    ram_we_d;
  logic [AW-1:0] ram_addr_q,  ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  tag_e          m_tag_q,     m_tag_d;

  // Idle cycles keep the previous address/data on the RAM bus; only en and
  // we drop. Video reads also leave wdata alone.
  always_comb begin
    m_tag_d     = TAG_NONE;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (i_vid_cen) begin
      m_tag_d    = TAG_VID;
      ram_addr_d = i_vid_addr;
    end else if (rr_gnt != 2'b00) begin
      m_tag_d     = cpu_tag(rr_gnt[1]);
      ram_we_d    = cpu_we[rr_gnt[1]];
      ram_addr_d  = cpu_addr[rr_gnt[1]];
      ram_wdata_d = cpu_wdata[rr_gnt[1]];
    end
    ram_en_d = (m_tag_d != TAG_NONE);
  end

  // ---------------------------------------------------------------------
  // Stages M, R and video output
  // ---------------------------------------------------------------------
  tag_e          r_tag_q;
  logic          r_we_q;
  logic          vid_valid_q;
  logic [DW-1:0] vid_rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m_tag_q     <= TAG_NONE;
      r_tag_q     <= TAG_NONE;
      r_we_q      <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_rdata_q <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      m_tag_q     <= m_tag_d;
      r_tag_q     <= m_tag_q;
      r_we_q      <= ram_we_q;
      // RAM data for the stage-R access is on i_ram_rdata now; it becomes
      // the stage-O output on the next cycle.
      vid_valid_q <= (r_tag_q == TAG_VID);
      if (r_tag_q == TAG_VID) begin
        vid_rdata_q <= i_ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-CPU busy flag and output stage
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_cpu
    localparam tag_e MY_TAG = (gi == 1) ? TAG_CPU1 : TAG_CPU0;

    logic          busy_q;
    logic          busy_d;
    logic          ack_q;
    logic [DW-1:0] rdata_q;

    // Set when granted; cleared at the end of the ack cycle so the CPU is
    // eligible again from the cycle after ack.
    always_comb begin
      busy_d = busy_q;
      if (m_tag_d == MY_TAG) begin
        busy_d = 1'b1;
      end else if (ack_q) begin
        busy_d = 1'b0;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        busy_q  <= 1'b0;
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        busy_q <= busy_d;
        ack_q  <= (r_tag_q == MY_TAG);
        if ((r_tag_q == MY_TAG) && !r_we_q) begin
          rdata_q <= i_ram_rdata;
        end
      end
    end

    assign busy[gi]      = busy_q;
    assign cpu_ack[gi]   = ack_q;
    assign cpu_rdata[gi] = rdata_q;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_ram_en     = ram_en_q;
  assign o_ram_we     = ram_we_q;
  assign o_ram_addr   = ram_addr_q;
  assign o_ram_wdata  = ram_wdata_q;
  assign o_vid_valid  = vid_valid_q;
  assign o_vid_rdata  = vid_rdata_q;
  assign o_cpu0_ack   = cpu_ack[0];
  assign o_cpu0_rdata = cpu_rdata[0];
  assign o_cpu1_ack   = cpu_ack[1];
  assign o_cpu1_rdata = cpu_rdata[1];

endmodule

// File: tb/tb_shared_ram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_ram_slot_arbiter
//   Self-checking bench for shared_ram_slot_arbiter. A behavioural RAM with
//   one-cycle read latency sits on the o_ram_* port. Each CPU access or video
//   strobe pushes its expected read data and latency window into a queue; a
//   negedge monitor pops and compares whenever an ack / valid appears.
// ---------------------------------------------------------------------------
module tb_shared_ram_slot_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_cen;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          cpu0_req, cpu0_we, cpu0_ack;
  logic [AW-1:0] cpu0_addr;
  logic [DW-1:0] cpu0_wdata, cpu0_rdata;
  logic          cpu1_req, cpu1_we, cpu1_ack;
  logic [AW-1:0] cpu1_addr;
  logic [DW-1:0] cpu1_wdata, cpu1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_ram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_vid_cen    (vid_cen),
    .i_vid_addr   (vid_addr),
    .o_vid_rdata  (vid_rdata),
    .o_vid_valid  (vid_valid),
    .i_cpu0_req   (cpu0_req),
    .i_cpu0_we    (cpu0_we),
    .i_cpu0_addr  (cpu0_addr),
    .i_cpu0_wdata (cpu0_wdata),
    .o_cpu0_ack   (cpu0_ack),
    .o_cpu0_rdata (cpu0_rdata),
    .i_cpu1_req   (cpu1_req),
    .i_cpu1_we    (cpu1_we),
    .i_cpu1_addr  (cpu1_addr),
    .i_cpu1_wdata (cpu1_wdata),
    .o_cpu1_ack   (cpu1_ack),
    .o_cpu1_rdata (cpu1_rdata),
    .o_ram_en     (ram_en),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata)
  );

  logic [47:0] outs;
  assign outs = {vid_rdata, vid_valid, cpu0_ack, cpu0_rdata, cpu1_ack, cpu1_rdata,
                 ram_en, ram_we, ram_addr, ram_wdata};

  // Unwritten RAM locations read back as a fixed address pattern.
  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'b10110};
  endfunction

  // Behavioural single-port RAM, read data one cycle after en.
  logic [7:0] ram_mem [2048];
  bit         ram_wr  [2048];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_wr[ram_addr]  <= 1'b1;
      end
      ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);
    end
  end

  // Reference memory, updated when stimulus is issued.
  logic [7:0] ref_mem [2048];
  bit         ref_wr  [2048];
  function automatic logic [7:0] ref_rd(input logic [10:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  typedef struct {
    bit         we;
    logic [7:0] rdata;
    int         issue;
    int         lat_min;   // < 0 : latency not checked
    int         lat_max;
  } exp_t;

  exp_t cpu_q0[$];
  exp_t cpu_q1[$];
  exp_t vid_q[$];

  // ---------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------
  exp_t       m_e;
  int         m_lat;
  logic [7:0] m_exp;
  logic [7:0] last_rd0 = '0;
  logic [7:0] last_rd1 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd0 = '0;
      last_rd1 = '0;
    end else begin
      if (cpu0_ack) begin
        checks++;
        if (cpu_q0.size() == 0) begin
          errors++;
          $display("FAIL cpu0_unexpected_ack cyc=%0d got ack required no ack", cyc);
        end else begin
          m_e   = cpu_q0.pop_front();
          m_lat = cyc - m_e.issue;
          m_exp = m_e.we ? last_rd0 : m_e.rdata;
          if (cpu0_rdata !== m_exp) begin
            errors++;
            $display("FAIL cpu0_rdata cyc=%0d got %h required %h", cyc, cpu0_rdata, m_exp);
          end
          if (!m_e.we) last_rd0 = m_e.rdata;
          if (m_e.lat_min >= 0) begin
            checks++;
            if (m_lat < m_e.lat_min || m_lat > m_e.lat_max) begin
              errors++;
              $display("FAIL cpu0_latency cyc=%0d got %0d required %0d..%0d", cyc, m_lat, m_e.lat_min, m_e.lat_max);
            end
          end
        end
      end
      if (cpu1_ack) begin
        checks++;
        if (cpu_q1.size() == 0) begin
          errors++;
          $display("FAIL cpu1_unexpected_ack cyc=%0d got ack required no ack", cyc);
        end else begin
          m_e   = cpu_q1.pop_front();
          m_lat = cyc - m_e.issue;
          m_exp = m_e.we ? last_rd1 : m_e.rdata;
          if (cpu1_rdata !== m_exp) begin
            errors++;
            $display("FAIL cpu1_rdata cyc=%0d got %h required %h", cyc, cpu1_rdata, m_exp);
          end
          if (!m_e.we) last_rd1 = m_e.rdata;
          if (m_e.lat_min >= 0) begin
            checks++;
            if (m_lat < m_e.lat_min || m_lat > m_e.lat_max) begin
              errors++;
              $display("FAIL cpu1_latency cyc=%0d got %0d required %0d..%0d", cyc, m_lat, m_e.lat_min, m_e.lat_max);
            end
          end
        end
      end
      if (vid_valid) begin
        checks++;
        if (vid_q.size() == 0) begin
          errors++;
          $display("FAIL vid_unexpected_valid cyc=%0d got valid required no valid", cyc);
        end else begin
          m_e   = vid_q.pop_front();
          m_lat = cyc - m_e.issue;
          if (vid_rdata !== m_e.rdata) begin
            errors++;
            $display("FAIL vid_rdata cyc=%0d got %h required %h", cyc, vid_rdata, m_e.rdata);
          end
          checks++;
          if (m_lat != 3) begin
            errors++;
            $display("FAIL vid_latency cyc=%0d got %0d required 3", cyc, m_lat);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus primitives (called at posedge+1)
  // ---------------------------------------------------------------------
  task automatic cpu_access(input int n, input bit we, input logic [10:0] addr,
                            input logic [7:0] wdata, input int lmin, input int lmax);
    exp_t e;
    bit   seen;
    e.we      = we;
    e.rdata   = ref_rd(addr);
    e.issue   = cyc;
    e.lat_min = lmin;
    e.lat_max = lmax;
    if (we) begin
      ref_mem[addr] = wdata;
      ref_wr[addr]  = 1'b1;
    end
    $display("cyc=%0d cpu%0d %s addr=%h wdata=%h", cyc, n, we ? "write" : "read", addr, wdata);
    if (n == 0) begin
      cpu_q0.push_back(e);
      cpu0_we = we; cpu0_addr = addr; cpu0_wdata = wdata; cpu0_req = 1'b1;
    end else begin
      cpu_q1.push_back(e);
      cpu1_we = we; cpu1_addr = addr; cpu1_wdata = wdata; cpu1_req = 1'b1;
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if ((n == 0 && cpu0_ack) || (n == 1 && cpu1_ack)) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL cpu%0d_ack_timeout addr=%h got no ack required ack within 20 clks", n, addr);
    end
    @(posedge clk); #1;
    if (n == 0) cpu0_req = 1'b0;
    else        cpu1_req = 1'b0;
  endtask

  task automatic vid_strobe(input logic [10:0] addr);
    exp_t e;
    e.we      = 1'b0;
    e.rdata   = ref_rd(addr);
    e.issue   = cyc;
    e.lat_min = 3;
    e.lat_max = 3;
    vid_q.push_back(e);
    $display("cyc=%0d vid strobe addr=%h", cyc, addr);
    vid_cen  = 1'b1;
    vid_addr = addr;
    @(posedge clk); #1;
    vid_cen = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    vid_cen = 1'b0; vid_addr = '0;
    cpu0_req = 1'b0; cpu0_we = 1'b0; cpu0_addr = '0; cpu0_wdata = '0;
    cpu1_req = 1'b0; cpu1_we = 1'b0; cpu1_addr = '0; cpu1_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 48'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", outs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== 48'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got %h required 0", cyc, outs);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_three_way;
    logic [10:0] exp_a [3];
    exp_a[0] = 11'h050;
    exp_a[1] = 11'h410;
    exp_a[2] = 11'h610;
    fork
      vid_strobe(11'h050);
      cpu_access(0, 1'b0, 11'h410, 8'h00, 4, 4);
      cpu_access(1, 1'b0, 11'h610, 8'h00, 5, 5);
      begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== exp_a[k]) begin
            errors++;
            $display("FAIL three_way_slot%0d got en=%b we=%b addr=%h required en=1 we=0 addr=%h", k, ram_en, ram_we, ram_addr, exp_a[k]);
          end
        end
      end
    join
    // The pointer should be back on CPU0: a fresh tie goes to CPU0 first.
    fork
      cpu_access(0, 1'b0, 11'h411, 8'h00, 3, 3);
      cpu_access(1, 1'b0, 11'h611, 8'h00, 4, 4);
      begin
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 11'h411) begin
          errors++;
          $display("FAIL rr_after_three_way got en=%b addr=%h required en=1 addr=411", ram_en, ram_addr);
        end
      end
    join
  endtask

  task automatic test_cpu_write_read;
    fork
      cpu_access(0, 1'b1, 11'h123, 8'hA5, 3, 3);
      begin
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 11'h123 || ram_wdata !== 8'hA5) begin
          errors++;
          $display("FAIL write_cmd got en=%b we=%b addr=%h wdata=%h required en=1 we=1 addr=123 wdata=a5", ram_en, ram_we, ram_addr, ram_wdata);
        end
      end
    join
    cpu_access(0, 1'b0, 11'h123, 8'h00, 3, 3);
    checks++;
    if (cpu0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_back_held got %h required a5", cpu0_rdata);
    end
  endtask

  task automatic test_alternate;
    exp_t e;
    int   g_who [16];
    int   g_cyc [16];
    int   ng, na0, na1, bad_alt, bad_gap;
    bit   done;
    ng = 0; na0 = 0; na1 = 0; bad_alt = 0; bad_gap = 0; done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e.we = 1'b0; e.issue = cyc; e.lat_min = -1; e.lat_max = -1;
      e.rdata = ref_rd(11'h420); cpu_q0.push_back(e);
      e.rdata = ref_rd(11'h620); cpu_q1.push_back(e);
    end
    cpu0_we = 1'b0; cpu0_addr = 11'h420; cpu0_req = 1'b1;
    cpu1_we = 1'b0; cpu1_addr = 11'h620; cpu1_req = 1'b1;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (ram_en && ng < 16) begin
        g_who[ng] = (ram_addr == 11'h420) ? 0 : 1;
        g_cyc[ng] = cyc;
        $display("cyc=%0d grant cpu%0d", cyc, g_who[ng]);
        ng++;
      end
      if (cpu0_ack) na0++;
      if (cpu1_ack) na1++;
      @(posedge clk); #1;
      if (na0 >= 5) cpu0_req = 1'b0;
      if (na1 >= 5) cpu1_req = 1'b0;
      if (na0 >= 5 && na1 >= 5) done = 1'b1;
    end
    cpu0_req = 1'b0;
    cpu1_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ng != 10 || na0 != 5 || na1 != 5) begin
      errors++;
      $display("FAIL alternate_counts got grants=%0d acks=%0d/%0d required 10 5/5", ng, na0, na1);
    end
    for (int i = 1; i < ng; i++) begin
      if (g_who[i] == g_who[i-1]) bad_alt++;
      if (i >= 2 && (g_cyc[i] - g_cyc[i-2]) < 4) bad_gap++;
    end
    checks++;
    if (bad_alt != 0) begin
      errors++;
      $display("FAIL alternate_order got %0d repeats required 0", bad_alt);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL alternate_busy_gap got %0d short gaps required 0", bad_gap);
    end
  endtask

  task automatic cpu_cen_driver(input int n, input int p0);
    int          next_c;
    logic [10:0] a;
    logic [7:0]  wd;
    bit          we;
    next_c = cyc;
    for (int r = 0; r < 12; r++) begin
      while (cyc < next_c) begin
        @(posedge clk); #1;
      end
      a      = (n == 0) ? 11'h400 : 11'h600;
      a[5:0] = 6'($urandom_range(63, 0));
      we     = 1'($urandom_range(1, 0));
      wd     = 8'($urandom_range(255, 0));
      cpu_access(n, we, a, wd, 3, 6);
      next_c += ((r % 2) == 0) ? p0 : (27 - p0);
    end
  endtask

  task automatic vid_driver;
    logic [10:0] va;
    for (int s = 0; s < 25; s++) begin
      va = 11'($urandom_range(255, 0));
      vid_strobe(va);
      repeat (7) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full_rate;
    fork
      vid_driver();
      cpu_cen_driver(0, 13);
      cpu_cen_driver(1, 14);
    join
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_access;
    int acks;
    acks = 0;
    cpu1_we = 1'b0; cpu1_addr = 11'h630; cpu1_req = 1'b1;
    $display("cyc=%0d cpu1 read addr=630 (to be aborted)", cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n    = 1'b0;
    cpu1_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== 48'd0) begin
        errors++;
        $display("FAIL mid_reset_outputs got %h required 0", outs);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu1_ack || cpu0_ack || vid_valid || ram_en) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL aborted_access_activity got %0d cycles required 0", acks);
    end
    @(posedge clk); #1;
    cpu_access(1, 1'b0, 11'h630, 8'h00, 3, 3);
    checks++;
    if (cpu1_rdata !== pat(11'h630)) begin
      errors++;
      $display("FAIL post_reset_read got %h required %h", cpu1_rdata, pat(11'h630));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_three_way();
    test_cpu_write_read();
    test_alternate();
    test_full_rate();
    test_reset_mid_access();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ((cpu_q0.size() + cpu_q1.size() + vid_q.size()) != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d/%0d pending required 0/0/0", cpu_q0.size(), cpu_q1.size(), vid_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
